// File: rtl/fwd_issue_stage_pkg.sv
// Shared definitions for the forwarding issue stage: state encoding and
// the stall-counter width with its saturating increment.
package fwd_issue_stage_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/fwd_issue_stage_fwd_mux.sv
// One operand's forwarding select: youngest matching source wins, falling
// back to register-file data; flags a hazard if the winner is not final.
module fwd_mux #(
  parameter int RAW  = 5,
  parameter int DW   = 32,
  parameter int NSRC = 3
) (
  input  logic                 rs_en,
  input  logic [RAW-1:0]       rs,
  input  logic [DW-1:0]        rf_data,
  input  logic [NSRC-1:0]      src_rd_en,
  input  logic [NSRC*RAW-1:0]  src_rd,
  input  logic [NSRC*DW-1:0]   src_data,
  input  logic [NSRC-1:0]      src_data_ok,
  output logic [DW-1:0]        data,
  output logic                 hazard
);

  logic found;

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    if (!rs_en || rs == '0) begin
      data = '0;
    end else begin
      // An older match must never override a younger one, even if the
      // younger one is still in flight.
      for (int i = 0; i < NSRC; i++) begin
        if (!found && src_rd_en[i] && src_rd[i*RAW +: RAW] == rs) begin
          found  = 1'b1;
          data   = src_data[i*DW +: DW];
          hazard = ~src_data_ok[i];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_issue_stage.sv
// Issue stage: resolves both source operands through forwarding, stalls on
// unresolved loads, and registers the instruction in a one-entry skid-free pipe.
module fwd_issue_stage
  import fwd_issue_stage_pkg::*;
#(
  parameter int RAW  = 5,
  parameter int DW   = 32,
  parameter int NSRC = 3,
  parameter int PW   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_rs_1_en,
  input  logic                i_rs_2_en,
  input  logic [RAW-1:0]      i_rs_1,
  input  logic [RAW-1:0]      i_rs_2,
  input  logic [DW-1:0]       i_rs_1_data,
  input  logic [DW-1:0]       i_rs_2_data,
  input  logic [PW-1:0]       i_payload,
  input  logic [NSRC-1:0]     i_src_rd_en,
  input  logic [NSRC*RAW-1:0] i_src_rd,
  input  logic [NSRC*DW-1:0]  i_src_data,
  input  logic [NSRC-1:0]     i_src_data_ok,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DW-1:0]       o_rs_1_data,
  output logic [DW-1:0]       o_rs_2_data,
  output logic [PW-1:0]       o_payload,
  output logic                o_hazard,
  output logic [31:0]         o_stall_cnt
);

  state_e           state_q, state_d;
  logic [DW-1:0]    rs_1_data_q, rs_1_data_d;
  logic [DW-1:0]    rs_2_data_q, rs_2_data_d;
  logic [PW-1:0]    payload_q, payload_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DW-1:0] rs_1_fwd, rs_2_fwd;
  logic          rs_1_haz, rs_2_haz;
  logic          capture;

  fwd_mux #(.RAW(RAW), .DW(DW), .NSRC(NSRC)) u_fwd_rs_1 (
    .rs_en       (i_rs_1_en),
    .rs          (i_rs_1),
    .rf_data     (i_rs_1_data),
    .src_rd_en   (i_src_rd_en),
    .src_rd      (i_src_rd),
    .src_data    (i_src_data),
    .src_data_ok (i_src_data_ok),
    .data        (rs_1_fwd),
    .hazard      (rs_1_haz)
  );

  fwd_mux #(.RAW(RAW), .DW(DW), .NSRC(NSRC)) u_fwd_rs_2 (
    .rs_en       (i_rs_2_en),
    .rs          (i_rs_2),
    .rf_data     (i_rs_2_data),
    .src_rd_en   (i_src_rd_en),
    .src_rd      (i_src_rd),
    .src_data    (i_src_data),
    .src_data_ok (i_src_data_ok),
    .data        (rs_2_fwd),
    .hazard      (rs_2_haz)
  );

  assign o_hazard = i_valid & (rs_1_haz | rs_2_haz);
  assign o_valid  = (state_q == ST_FULL);
  assign o_ready  = ~o_hazard & (~o_valid | i_ready);
  // A flush drops the incoming instruction even though o_ready may be high.
  assign capture  = i_valid & o_ready & ~i_flush;

  always_comb begin
    state_d     = state_q;
    rs_1_data_d = rs_1_data_q;
    rs_2_data_d = rs_2_data_q;
    payload_d   = payload_q;
    stall_cnt_d = stall_cnt_q;

    if (capture) begin
      rs_1_data_d = rs_1_fwd;
      rs_2_data_d = rs_2_fwd;
      payload_d   = i_payload;
    end

    if (o_hazard && !i_flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end

    case (state_q)
      ST_EMPTY: if (capture) state_d = ST_FULL;
      ST_FULL:  if (!capture && i_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (i_flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rs_1_data_q <= '0;
      rs_2_data_q <= '0;
      payload_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rs_1_data_q <= rs_1_data_d;
      rs_2_data_q <= rs_2_data_d;
      payload_q   <= payload_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_rs_1_data = rs_1_data_q;
  assign o_rs_2_data = rs_2_data_q;
  assign o_payload   = payload_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_issue_stage.sv
// Randomized and directed bench for fwd_issue_stage against a spec-level model.
module tb_fwd_issue_stage;

  localparam int RAW  = 5;
  localparam int DW   = 32;
  localparam int NSRC = 3;
  localparam int PW   = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_flush, i_valid, o_ready;
  logic                i_rs_1_en, i_rs_2_en;
  logic [RAW-1:0]      i_rs_1, i_rs_2;
  logic [DW-1:0]       i_rs_1_data, i_rs_2_data;
  logic [PW-1:0]       i_payload;
  logic [NSRC-1:0]     i_src_rd_en;
  logic [NSRC*RAW-1:0] i_src_rd;
  logic [NSRC*DW-1:0]  i_src_data;
  logic [NSRC-1:0]     i_src_data_ok;
  logic                o_valid, i_ready;
  logic [DW-1:0]       o_rs_1_data, o_rs_2_data;
  logic [PW-1:0]       o_payload;
  logic                o_hazard;
  logic [31:0]         o_stall_cnt;

  logic           s_en  [NSRC];
  logic [RAW-1:0] s_rd  [NSRC];
  logic [DW-1:0]  s_dat [NSRC];
  logic           s_ok  [NSRC];

  int checks = 0;
  int errors = 0;

  // reference model of the registered stage
  logic          m_valid;
  logic [DW-1:0] m_r1, m_r2;
  logic [PW-1:0] m_pl;
  logic [31:0]   m_cnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NSRC; g++) begin : g_pack
    assign i_src_rd_en[g]              = s_en[g];
    assign i_src_rd[g*RAW +: RAW]      = s_rd[g];
    assign i_src_data[g*DW +: DW]      = s_dat[g];
    assign i_src_data_ok[g]            = s_ok[g];
  end

  fwd_issue_stage #(.RAW(RAW), .DW(DW), .NSRC(NSRC), .PW(PW)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs_1_en(i_rs_1_en), .i_rs_2_en(i_rs_2_en), .i_rs_1(i_rs_1), .i_rs_2(i_rs_2),
    .i_rs_1_data(i_rs_1_data), .i_rs_2_data(i_rs_2_data), .i_payload(i_payload),
    .i_src_rd_en(i_src_rd_en), .i_src_rd(i_src_rd), .i_src_data(i_src_data),
    .i_src_data_ok(i_src_data_ok), .o_valid(o_valid), .i_ready(i_ready),
    .o_rs_1_data(o_rs_1_data), .o_rs_2_data(o_rs_2_data), .o_payload(o_payload),
    .o_hazard(o_hazard), .o_stall_cnt(o_stall_cnt)
  );

  // Operand value: x0/disabled reads zero, else youngest matching source, else regfile.
  function automatic void resolve(input logic en, input logic [RAW-1:0] rs,
                                  input logic [DW-1:0] rf,
                                  output logic [DW-1:0] d, output logic h);
    d = rf;
    h = 1'b0;
    if (!en || rs == 0) begin
      d = '0;
      return;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (s_en[i] && s_rd[i] == rs) begin
        d = s_dat[i];
        h = !s_ok[i];
        return;
      end
    end
  endfunction

  task automatic idle_inputs();
    i_flush = 0; i_valid = 0; i_ready = 0;
    i_rs_1_en = 0; i_rs_2_en = 0; i_rs_1 = 0; i_rs_2 = 0;
    i_rs_1_data = 0; i_rs_2_data = 0; i_payload = 0;
    for (int i = 0; i < NSRC; i++) begin
      s_en[i] = 0; s_rd[i] = 0; s_dat[i] = 0; s_ok[i] = 1;
    end
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic cycle_check(input string tag);
    logic [DW-1:0] d1, d2;
    logic h1, h2, haz, rdy, cap;
    #1;
    resolve(i_rs_1_en, i_rs_1, i_rs_1_data, d1, h1);
    resolve(i_rs_2_en, i_rs_2, i_rs_2_data, d2, h2);
    haz = i_valid && (h1 || h2);
    rdy = !haz && (!m_valid || i_ready);
    checks++;
    if (o_hazard !== haz) begin
      errors++; $display("FAIL %s hazard got %0b want %0b", tag, o_hazard, haz);
    end
    checks++;
    if (o_ready !== rdy) begin
      errors++; $display("FAIL %s ready got %0b want %0b", tag, o_ready, rdy);
    end
    if (haz && !i_flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    cap = i_valid && rdy && !i_flush;
    if (cap) begin
      m_r1 = d1; m_r2 = d2; m_pl = i_payload;
    end
    if (i_flush)                 m_valid = 0;
    else if (cap)                m_valid = 1;
    else if (m_valid && i_ready) m_valid = 0;
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== m_valid) begin
      errors++; $display("FAIL %s o_valid got %0b want %0b", tag, o_valid, m_valid);
    end
    checks++;
    if (o_rs_1_data !== m_r1) begin
      errors++; $display("FAIL %s rs_1_data got %h want %h", tag, o_rs_1_data, m_r1);
    end
    checks++;
    if (o_rs_2_data !== m_r2) begin
      errors++; $display("FAIL %s rs_2_data got %h want %h", tag, o_rs_2_data, m_r2);
    end
    checks++;
    if (o_payload !== m_pl) begin
      errors++; $display("FAIL %s payload got %h want %h", tag, o_payload, m_pl);
    end
    checks++;
    if (o_stall_cnt !== m_cnt) begin
      errors++; $display("FAIL %s stall_cnt got %h want %h", tag, o_stall_cnt, m_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #3;
    checks++;
    if (o_valid !== 0 || o_rs_1_data !== 0 || o_rs_2_data !== 0 || o_payload !== 0 ||
        o_stall_cnt !== 0) begin
      errors++;
      $display("FAIL reset outputs got v=%0b r1=%h r2=%h pl=%h cnt=%h want all 0",
               o_valid, o_rs_1_data, o_rs_2_data, o_payload, o_stall_cnt);
    end
    m_valid = 0; m_r1 = 0; m_r2 = 0; m_pl = 0; m_cnt = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_fwd_priority();
    test_reset();
    i_valid = 1; i_ready = 1; i_rs_1_en = 1; i_rs_1 = 5; i_rs_1_data = 32'h5555;
    i_payload = 64'h1;
    s_en[0] = 1; s_rd[0] = 5; s_dat[0] = 32'hAAAA; s_ok[0] = 1;
    s_en[2] = 1; s_rd[2] = 5; s_dat[2] = 32'hBBBB; s_ok[2] = 1;
    cycle_check("fwd_priority");
    checks++;
    if (o_rs_1_data !== 32'hAAAA) begin
      errors++; $display("FAIL fwd_priority_lit got %h want 0000aaaa", o_rs_1_data);
    end
    idle_inputs();
  endtask

  task automatic test_load_hazard();
    test_reset();
    i_valid = 1; i_rs_2_en = 1; i_rs_2 = 7; i_rs_2_data = 32'h7777; i_payload = 64'h2;
    s_en[0] = 1; s_rd[0] = 7; s_ok[0] = 0; s_dat[0] = 32'hDEAD;
    s_en[1] = 1; s_rd[1] = 7; s_ok[1] = 1; s_dat[1] = 32'h9999;
    repeat (2) cycle_check("load_hazard_stall");
    checks++;
    if (o_stall_cnt !== 32'd2) begin
      errors++; $display("FAIL load_hazard_cnt got %0d want 2", o_stall_cnt);
    end
    s_ok[0] = 1; s_dat[0] = 32'h1234;
    cycle_check("load_hazard_release");
    checks++;
    if (o_rs_2_data !== 32'h1234 || o_valid !== 1) begin
      errors++; $display("FAIL load_hazard_data got %h v=%0b want 00001234 v=1", o_rs_2_data, o_valid);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    test_reset();
    i_valid = 1; i_ready = 1; i_rs_1_en = 1; i_rs_1 = 0; i_rs_1_data = 32'hCCCC;
    s_en[0] = 1; s_rd[0] = 0; s_dat[0] = 32'hFFFF; s_ok[0] = 0;
    cycle_check("zero_reg");
    checks++;
    if (o_rs_1_data !== 0 || o_valid !== 1) begin
      errors++; $display("FAIL zero_reg_lit got %h v=%0b want 0 v=1", o_rs_1_data, o_valid);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] held;
    test_reset();
    i_valid = 1; i_ready = 0; i_rs_1_en = 1; i_rs_1 = 3; i_rs_1_data = 32'hA0A0;
    i_payload = 64'hA;
    cycle_check("b2b_first");
    held = o_rs_1_data;
    i_rs_1_data = 32'hB0B0; i_payload = 64'hB;
    repeat (3) cycle_check("b2b_hold");
    checks++;
    if (o_rs_1_data !== held || o_ready !== 0 || held !== 32'hA0A0) begin
      errors++; $display("FAIL b2b_hold_lit got %h rdy=%0b want 0000a0a0 rdy=0", o_rs_1_data, o_ready);
    end
    i_ready = 1;
    cycle_check("b2b_next");
    checks++;
    if (o_rs_1_data !== 32'hB0B0 || o_valid !== 1) begin
      errors++; $display("FAIL b2b_next_lit got %h v=%0b want 0000b0b0 v=1", o_rs_1_data, o_valid);
    end
    idle_inputs();
    cycle_check("b2b_drain");
  endtask

  task automatic test_flush();
    test_reset();
    i_valid = 1; i_rs_1_en = 1; i_rs_1 = 4; i_rs_1_data = 32'h1111; i_payload = 64'h11;
    cycle_check("flush_fill");
    i_flush = 1; i_ready = 1; i_rs_1_data = 32'h2222; i_payload = 64'h22;
    cycle_check("flush");
    checks++;
    if (o_valid !== 0 || o_rs_1_data !== 32'h1111) begin
      errors++; $display("FAIL flush_lit got v=%0b r1=%h want v=0 r1=00001111", o_valid, o_rs_1_data);
    end
    idle_inputs();
    cycle_check("flush_after");
  endtask

  task automatic test_stall_sat();
    test_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    i_valid = 1; i_rs_1_en = 1; i_rs_1 = 3;
    s_en[0] = 1; s_rd[0] = 3; s_ok[0] = 0;
    cycle_check("sat_1");
    repeat (2) cycle_check("sat_n");
    checks++;
    if (o_stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_lit got %h want ffffffff", o_stall_cnt);
    end
    s_ok[0] = 1;
    cycle_check("sat_fill");
    test_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      i_flush     = ($urandom_range(0, 9) == 0);
      i_valid     = ($urandom_range(0, 9) < 7);
      i_ready     = ($urandom_range(0, 9) < 6);
      i_rs_1_en   = ($urandom_range(0, 7) != 0);
      i_rs_2_en   = ($urandom_range(0, 7) != 0);
      i_rs_1      = RAW'($urandom_range(0, 3));
      i_rs_2      = RAW'($urandom_range(0, 3));
      i_rs_1_data = $urandom;
      i_rs_2_data = $urandom;
      i_payload   = {$urandom, $urandom};
      for (int i = 0; i < NSRC; i++) begin
        s_en[i]  = $urandom_range(0, 1);
        s_rd[i]  = RAW'($urandom_range(0, 3));
        s_dat[i] = $urandom;
        s_ok[i]  = ($urandom_range(0, 3) != 0);
      end
      cycle_check("random");
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_valid = 0; m_r1 = 0; m_r2 = 0; m_pl = 0; m_cnt = 0;
    test_reset();
    test_fwd_priority();
    test_load_hazard();
    test_zero_reg();
    test_back_to_back();
    test_flush();
    test_stall_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
